// File: rtl/apb_master_req.sv
// APB initiator: single-command valid/ready requests become APB transfers, with a
// buffered response and a watchdog that aborts transfers stuck in ACCESS.
module apb_master_req #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic          TMO_EN   = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]    state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          pwrite_q, pwrite_d;
    logic [31:0]   paddr_q,  paddr_d;
    logic [31:0]   pwdata_q, pwdata_d;
    logic [31:0]   rdata_q,  rdata_d;
    logic          err_q,    err_d;
    logic          tmo_q,    tmo_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
                    rdata_d = pwrite_q ? 32'd0 : PRDATA;
                    err_d   = PSLVERR;
                    tmo_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    // Saturate so a disabled watchdog never wraps the count.
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (TMO_EN && (cnt_q == CNT_LAST)) begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                        tmo_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= 32'd0;
            pwdata_q <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    // Control outputs decode straight from state so reset drops them immediately.
    assign cmd_ready   = (state_q == ST_IDLE);
    assign PSEL        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE     = (state_q == ST_ACCESS);
    assign rsp_valid   = (state_q == ST_RESP);
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_apb_master_req.sv
// Directed bench for apb_master_req with an 8-cycle watchdog; the APB slave is
// scripted per transfer (wait states, read data, error flag).
module tb_apb_master_req;

    localparam int TMO = 8;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] PADDR, PWDATA, PRDATA;

    int n_tests = 0;
    int n_fail  = 0;
    int acc, lat, setups;

    apb_master_req #(.TIMEOUT_CYCLES(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    // Issue one command and play the slave until rsp_valid; rsp_ready is left low.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int waits, input logic [31:0] rd, input logic err,
                        output int n_acc, output int n_lat, output int n_setup);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        tick;
        cmd_valid = 1'b0;
        n_acc = 0;
        n_lat = 1;
        n_setup = 0;
        while (!rsp_valid && n_lat < 60) begin
            if (PSEL && !PENABLE) begin
                n_setup++;
                check_eq("setup_paddr", PADDR, a);
                check_eq("setup_pwrite", 32'(PWRITE), 32'(wr));
                check_eq("setup_pwdata", PWDATA, d);
            end
            if (PSEL && PENABLE) begin
                check_eq("access_paddr", PADDR, a);
                PREADY  = (n_acc >= waits);
                PRDATA  = rd;
                PSLVERR = err;
                n_acc++;
            end else begin
                PREADY = 1'b0;
            end
            tick;
            n_lat++;
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        $display("[TB] xfer wr=%0d addr=0x%08h waits=%0d -> access=%0d lat=%0d rdata=0x%08h err=%0d tmo=%0d",
                 wr, a, waits, n_acc, n_lat, rsp_rdata, rsp_err, rsp_timeout);
    endtask

    task automatic finish_rsp;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        rsp_ready = 0; PRDATA = 0; PREADY = 0; PSLVERR = 0;
        #2;
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_psel", 32'(PSEL), 32'd0);
        check_eq("rst_penable", 32'(PENABLE), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_paddr", PADDR, 32'd0);
        tick; tick;
        PRESETn = 1'b1;
        tick;

        // Zero-wait write: read data bus must not leak into the response.
        xfer(1'b1, 32'h0, 32'h1, 0, 32'hDEAD, 1'b0, acc, lat, setups);
        check_eq("wr_setup_cycles", 32'(setups), 32'd1);
        check_eq("wr_access_cycles", 32'(acc), 32'd1);
        check_eq("wr_latency", 32'(lat), 32'd3);
        check_eq("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("wr_rdata", rsp_rdata, 32'd0);
        check_eq("wr_err", 32'(rsp_err), 32'd0);
        check_eq("wr_psel_resp", 32'(PSEL), 32'd0);
        finish_rsp;

        // Read with 3 wait states.
        xfer(1'b0, 32'h4, 32'h0, 3, 32'h0000_0ABC, 1'b0, acc, lat, setups);
        check_eq("rd_access_cycles", 32'(acc), 32'd4);
        check_eq("rd_latency", 32'(lat), 32'd6);
        check_eq("rd_rdata", rsp_rdata, 32'h0000_0ABC);
        check_eq("rd_err", 32'(rsp_err), 32'd0);
        check_eq("rd_tmo", 32'(rsp_timeout), 32'd0);
        finish_rsp;

        // Slave error on completion.
        xfer(1'b0, 32'h8, 32'h0, 0, 32'h1234_5678, 1'b1, acc, lat, setups);
        check_eq("slverr_err", 32'(rsp_err), 32'd1);
        check_eq("slverr_tmo", 32'(rsp_timeout), 32'd0);
        check_eq("slverr_rdata", rsp_rdata, 32'h1234_5678);
        finish_rsp;

        // Stuck slave: watchdog aborts after TMO ACCESS cycles.
        xfer(1'b0, 32'hC, 32'h0, 1000, 32'hFFFF, 1'b0, acc, lat, setups);
        check_eq("tmo_access_cycles", 32'(acc), 32'(TMO));
        check_eq("tmo_err", 32'(rsp_err), 32'd1);
        check_eq("tmo_flag", 32'(rsp_timeout), 32'd1);
        check_eq("tmo_rdata", rsp_rdata, 32'd0);
        finish_rsp;
        check_eq("idle_paddr_hold", PADDR, 32'hC);

        // PREADY on the final watchdog cycle completes normally.
        xfer(1'b1, 32'h10, 32'h55, TMO - 1, 32'h0, 1'b0, acc, lat, setups);
        check_eq("edge_access_cycles", 32'(acc), 32'(TMO));
        check_eq("edge_tmo", 32'(rsp_timeout), 32'd0);
        check_eq("edge_err", 32'(rsp_err), 32'd0);
        finish_rsp;

        // Response backpressure with a new command waiting.
        xfer(1'b0, 32'h14, 32'h0, 0, 32'hBEEF, 1'b0, acc, lat, setups);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h18; cmd_wdata = 32'h77;
        for (int i = 0; i < 5; i++) begin
            tick;
            check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp_rdata", rsp_rdata, 32'hBEEF);
            check_eq("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check_eq("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("bp_idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("bp_idle_psel", 32'(PSEL), 32'd0);
        tick;
        cmd_valid = 1'b0;
        check_eq("bp_setup_psel", 32'(PSEL), 32'd1);
        check_eq("bp_setup_penable", 32'(PENABLE), 32'd0);
        check_eq("bp_setup_paddr", PADDR, 32'h18);
        tick;
        PREADY = 1'b1;
        tick;
        PREADY = 1'b0;
        check_eq("bp2_rsp_valid", 32'(rsp_valid), 32'd1);
        $display("[TB] xfer wr=1 addr=0x00000018 queued behind backpressure -> rdata=0x%08h", rsp_rdata);
        finish_rsp;

        // Reset asserted while in ACCESS.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
        tick;
        cmd_valid = 1'b0;
        tick;
        check_eq("mid_penable", 32'(PENABLE), 32'd1);
        #2 PRESETn = 1'b0;
        #1;
        check_eq("mid_rst_psel", 32'(PSEL), 32'd0);
        check_eq("mid_rst_penable", 32'(PENABLE), 32'd0);
        check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        tick; tick;
        PRESETn = 1'b1;
        tick;
        check_eq("rel_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rel_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rel_psel", 32'(PSEL), 32'd0);
        $display("[TB] reset during ACCESS addr=0x00000020 -> rsp_valid=%0d cmd_ready=%0d", rsp_valid, cmd_ready);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
